// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and the conditional-negate helper for the sequential multiplier
package mult_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
  function automatic logic [63:0] neg_if(input logic [63:0] x, input logic n);
    return n ? -x : x;
  endfunction
endpackage

// File: rtl/mult_secuencial_param_if.sv
// mult_secuencial_param_if: start/busy/done handshake and operand/result bus of the multiplier
interface mult_secuencial_param_if #(parameter int WIDTH = 8);
  localparam int CW = $clog2(WIDTH + 1);
  logic start, sgn, busy, done;
  logic [WIDTH-1:0] a, b;
  logic [2*WIDTH-1:0] c;
  logic [CW-1:0] contador;
  modport master(output start, a, b, sgn, input c, contador, busy, done);
  modport slave(input start, a, b, sgn, output c, contador, busy, done);
endinterface

// File: rtl/mult_secuencial_param.sv
// mult_secuencial_param: shift-add multiplier, one multiplier bit per clock; signed mode under MULT_SIGNED_EN
module mult_secuencial_param
  import mult_pkg::*;
#(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  mult_secuencial_param_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state;
  logic [2*WIDTH-1:0] acc, mcand, acc_next, result;
  logic [WIDTH-1:0] mplier, ma, mb;
  always_comb acc_next = mplier[0] ? acc + mcand : acc;
`ifdef MULT_SIGNED_EN
  logic neg;
  // truncating the 64-bit negate keeps -2^(WIDTH-1) as its unsigned magnitude
  always_comb begin
    ma = bus.sgn ? WIDTH'(neg_if(64'(bus.a), bus.a[WIDTH-1])) : bus.a;
    mb = bus.sgn ? WIDTH'(neg_if(64'(bus.b), bus.b[WIDTH-1])) : bus.b;
    result = (2*WIDTH)'(neg_if(64'(acc_next), neg));
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) neg <= 1'b0;
    else if (state != CALC && bus.start) neg <= bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
`else
  always_comb begin
    ma = bus.a;
    mb = bus.b;
    result = acc_next;
  end
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      bus.c <= '0;
      bus.contador <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state != CALC && bus.start) begin
        state <= CALC;
        acc <= '0;
        mcand <= {{WIDTH{1'b0}}, ma};
        mplier <= mb;
        bus.contador <= '0;
        bus.busy <= 1'b1;
      end else if (state == CALC) begin
        acc <= acc_next;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        bus.contador <= bus.contador + 1'b1;
        if (bus.contador == CW'(WIDTH - 1)) begin
          state <= DONE;
          bus.c <= result;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end
      end else state <= IDLE;
    end
  end
endmodule

// File: tb/tb_mult_secuencial_param.sv
// tb_mult_secuencial_param: directed vectors for 8- and 16-bit instances, latency, handshake and async reset
module tb_mult_secuencial_param;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  mult_secuencial_param_if #(.WIDTH(8)) m8();
  mult_secuencial_param_if #(.WIDTH(16)) m16();
  mult_secuencial_param #(.WIDTH(8)) u8(.clk(clk), .rst(rst), .bus(m8));
  mult_secuencial_param #(.WIDTH(16)) u16(.clk(clk), .rst(rst), .bus(m16));
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start8(input logic [7:0] x, input logic [7:0] y, input logic s);
    m8.a = x;
    m8.b = y;
    m8.sgn = s;
    m8.start = 1'b1;
    tick();
    m8.start = 1'b0;
  endtask
  task automatic wait_done8(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!m8.done && cyc < 40);
    if (!m8.done) chk("done8_timeout", 64'd0, 64'd1);
  endtask
  int cyc, extra;
  initial begin
    {m8.start, m8.sgn, m8.a, m8.b} = '0;
    {m16.start, m16.sgn, m16.a, m16.b} = '0;
    #1 rst = 1'b0;
    #2;
    chk("rst_c", 64'(m8.c), 0);
    chk("rst_cnt", 64'(m8.contador), 0);
    chk("rst_busy", 64'(m8.busy), 0);
    chk("rst_done", 64'(m8.done), 0);
    @(negedge clk) rst = 1'b1;
    tick();
    // basic unsigned operation and fixed latency
    start8(8'd13, 8'd11, 1'b0);
    chk("t1_busy", 64'(m8.busy), 1);
    wait_done8(cyc);
    chk("t1_lat", 64'(cyc), 8);
    chk("t1_c", 64'(m8.c), 64'h8F);
    chk("t1_cnt", 64'(m8.contador), 8);
    chk("t1_busy_done", 64'(m8.busy), 0);
    tick();
    chk("t1_pulse", 64'(m8.done), 0);
    tick();
    chk("t1_cnt_hold", 64'(m8.contador), 8);
    chk("t1_c_hold", 64'(m8.c), 64'h8F);
    // back-to-back with start held through CALC and DONE
    m8.a = 8'd255;
    m8.b = 8'd255;
    m8.start = 1'b1;
    tick();
    m8.a = 8'd0;
    m8.b = 8'd200;
    wait_done8(cyc);
    chk("t2_lat", 64'(cyc), 8);
    chk("t2_c", 64'(m8.c), 64'hFE01);
    tick();
    chk("t2_b2b_busy", 64'(m8.busy), 1);
    chk("t2_b2b_done", 64'(m8.done), 0);
    m8.start = 1'b0;
    wait_done8(cyc);
    chk("t2_b2b_lat", 64'(cyc), 8);
    chk("t2_b2b_c", 64'(m8.c), 0);
    // start during CALC is ignored
    start8(8'd7, 8'd9, 1'b0);
    tick();
    tick();
    m8.a = 8'd1;
    m8.b = 8'd1;
    m8.start = 1'b1;
    tick();
    m8.start = 1'b0;
    wait_done8(cyc);
    chk("t3_lat", 64'(cyc), 5);
    chk("t3_c", 64'(m8.c), 64'd63);
    extra = 0;
    repeat (12) begin
      tick();
      if (m8.done) extra++;
    end
    chk("t3_extra_done", 64'(extra), 0);
    chk("t3_idle_busy", 64'(m8.busy), 0);
    // asynchronous reset mid-CALC
    start8(8'd200, 8'd100, 1'b0);
    repeat (4) tick();
    chk("t4_cnt_mid", 64'(m8.contador), 4);
    #2 rst = 1'b0;
    #1;
    chk("t4_rst_c", 64'(m8.c), 0);
    chk("t4_rst_cnt", 64'(m8.contador), 0);
    chk("t4_rst_busy", 64'(m8.busy), 0);
    chk("t4_rst_done", 64'(m8.done), 0);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    extra = 0;
    repeat (12) begin
      tick();
      if (m8.done) extra++;
    end
    chk("t4_no_done", 64'(extra), 0);
    start8(8'd3, 8'd4, 1'b0);
    wait_done8(cyc);
    chk("t4_lat", 64'(cyc), 8);
    chk("t4_c", 64'(m8.c), 64'd12);
    // signed mode (unsigned results when the feature is compiled out)
    start8(8'h80, 8'h80, 1'b1);
    wait_done8(cyc);
    chk("t5_min_sq", 64'(m8.c), 64'h4000);
    start8(8'hFD, 8'd5, 1'b1);
    wait_done8(cyc);
`ifdef MULT_SIGNED_EN
    chk("t5_neg", 64'(m8.c), 64'hFFF1);
`else
    chk("t5_neg", 64'(m8.c), 64'h04F1);
`endif
    start8(8'h80, 8'h02, 1'b1);
    wait_done8(cyc);
`ifdef MULT_SIGNED_EN
    chk("t5_min_x2", 64'(m8.c), 64'hFF00);
`else
    chk("t5_min_x2", 64'(m8.c), 64'h0100);
`endif
    start8(8'h80, 8'h02, 1'b0);
    wait_done8(cyc);
    chk("t5_unsigned", 64'(m8.c), 64'h0100);
    // 16-bit instance
    m16.a = 16'hFFFF;
    m16.b = 16'h0002;
    m16.start = 1'b1;
    tick();
    m16.start = 1'b0;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!m16.done && cyc < 60);
    chk("t6_lat", 64'(cyc), 16);
    chk("t6_c", 64'(m16.c), 64'h0001FFFE);
    chk("t6_cnt", 64'(m16.contador), 16);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
